// File: rtl/i2c_pkg.sv
// Shared I2C definitions: slave FSM states, R/W bit encoding and bus timing
// defaults used by both the master and the memory slave.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    ACK_ADDR,
    GET_DATA,
    ACK_DATA,
    SEND_DATA,
    GET_MACK,
    WAIT_STOP
  } slave_state_e;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam int unsigned FREQ_SYSTEM = 50_000_000;
  localparam int unsigned FREQ_I2C    = 100_000;

endpackage

// File: rtl/i2c_mem_slave_if.sv
// Slave-side signal bundle: SCL from the master plus the slave status strobes
// and the FSM state exposed for observation.
interface i2c_mem_slave_if;

  logic                 scl;
  logic                 busy;
  logic                 done;
  logic                 ack_err;
  logic                 wr_strobe;
  i2c_pkg::slave_state_e dbg_state;

  modport slave  (input scl, output busy, done, ack_err, wr_strobe, dbg_state);
  modport master (output scl, input busy, done, ack_err, wr_strobe, dbg_state);

endinterface

// File: rtl/i2c_bus_sync.sv
// Synchronises SCL/SDA onto clk and derives SCL edges plus START/STOP.
// Synchroniser flops reset high so a released bus never looks like an event.
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_d;
  logic                   sda_d;
  logic                   scl_s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign sda_s = sda_sync[SYNC_STAGES-1];

  assign scl_rise  =  scl_s & ~scl_d;
  assign scl_fall  = ~scl_s &  scl_d;
  // SDA may only change with SCL stably high for a bus condition.
  assign start_det =  scl_s &  scl_d &  sda_d & ~sda_s;
  assign stop_det  =  scl_s &  scl_d & ~sda_d &  sda_s;

endmodule

// File: rtl/i2c_mem_slave.sv
// Single-byte I2C slave fronting a 128x8 register memory: one write byte or
// one read byte per transaction, open-drain SDA, no clock stretching.
module i2c_mem_slave
  import i2c_pkg::*;
#(
  parameter int ADDR_W      = 7,
  parameter int DEPTH       = 128,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  inout  wire  sda,
  i2c_mem_slave_if.slave bus
);

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .rst       (rst),
    .scl       (bus.scl),
    .sda       (sda),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  slave_state_e      state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shreg_q, shreg_d;
  logic              byte_full_q, byte_full_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rw_q, rw_d;
  logic              sda_oe_q, sda_oe_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ack_err_q, ack_err_d;
  logic              wr_q, wr_d;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic [7:0]        rd_byte;
  logic [7:0]        mem [DEPTH];

  assign rd_byte = mem[addr_q];

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    byte_full_d = byte_full_q;
    addr_d      = addr_q;
    rw_d        = rw_q;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    ack_err_d   = ack_err_q;
    done_d      = 1'b0;
    wr_d        = 1'b0;
    mem_we      = 1'b0;
    mem_wdata   = {shreg_q[6:0], sda_s};

    if (start_det) begin
      state_d     = GET_ADDR;
      bit_cnt_d   = 3'd0;
      byte_full_d = 1'b0;
      sda_oe_d    = 1'b0;
      busy_d      = 1'b1;
      ack_err_d   = 1'b0;
    end else if (stop_det) begin
      state_d     = IDLE;
      bit_cnt_d   = 3'd0;
      byte_full_d = 1'b0;
      sda_oe_d    = 1'b0;
      busy_d      = 1'b0;
      done_d      = (state_q == WAIT_STOP);
    end else begin
      case (state_q)
        GET_ADDR, GET_DATA: begin
          // byte_full holds off further shifting until the ACK slot starts.
          if (scl_rise && !byte_full_q) begin
            shreg_d   = {shreg_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              byte_full_d = 1'b1;
              if (state_q == GET_ADDR) begin
                addr_d = shreg_q[ADDR_W-1:0];
                rw_d   = sda_s;
              end else begin
                mem_we = 1'b1;
                wr_d   = 1'b1;
              end
            end
          end else if (scl_fall && byte_full_q) begin
            byte_full_d = 1'b0;
            sda_oe_d    = 1'b1;
            state_d     = (state_q == GET_ADDR) ? ACK_ADDR : ACK_DATA;
          end
        end
        ACK_ADDR: begin
          if (scl_fall) begin
            bit_cnt_d = 3'd0;
            if (rw_q == RW_READ) begin
              state_d  = SEND_DATA;
              shreg_d  = rd_byte;
              sda_oe_d = ~rd_byte[7];
            end else begin
              state_d  = GET_DATA;
              sda_oe_d = 1'b0;
            end
          end
        end
        ACK_DATA: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            state_d  = WAIT_STOP;
          end
        end
        SEND_DATA: begin
          // MSB went out on entry; each fall presents the next bit.
          if (scl_fall) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              sda_oe_d = 1'b0;
              state_d  = GET_MACK;
            end else begin
              shreg_d  = {shreg_q[6:0], 1'b0};
              sda_oe_d = ~shreg_q[6];
            end
          end
        end
        GET_MACK: begin
          if (scl_rise) begin
            if (sda_s) ack_err_d = 1'b1;
            state_d = WAIT_STOP;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      shreg_q     <= 8'h00;
      byte_full_q <= 1'b0;
      addr_q      <= '0;
      rw_q        <= RW_WRITE;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ack_err_q   <= 1'b0;
      wr_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      byte_full_q <= byte_full_d;
      addr_q      <= addr_d;
      rw_q        <= rw_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ack_err_q   <= ack_err_d;
      wr_q        <= wr_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
    end else if (mem_we) begin
      mem[addr_q] <= mem_wdata;
    end
  end

  assign sda           = sda_oe_q ? 1'b0 : 1'bz;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.ack_err   = ack_err_q;
  assign bus.wr_strobe = wr_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_i2c_mem_slave.sv
// Bench for i2c_mem_slave: a bit-level I2C master drives directed transactions
// against a transaction-level memory model; a per-cycle compare watches status.
`timescale 1ns/1ps
module tb_i2c_mem_slave;

  localparam int QC = 8;

  logic clk;
  logic rst;
  logic m_oe;
  wire  sda;

  assign sda = m_oe ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_mem_slave_if bus ();

  i2c_mem_slave #(.ADDR_W(7), .DEPTH(128), .SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .sda (sda),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model and scoreboard state
  logic [7:0] model_mem [128];
  logic [7:0] exp_q [$];
  logic       model_busy;
  logic       model_ack_err;
  logic       txn_complete;
  int         exp_wr, exp_done, act_wr, act_done;
  int         cycle_cnt, last_evt;
  int         checks, failures;
  logic       sim_done;
  logic [7:0] rd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic mark();
    last_evt = cycle_cnt;
  endtask

  task automatic q();
    repeat (QC) @(negedge clk);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 128; i++) model_mem[i] = 8'h00;
    model_busy    = 1'b0;
    model_ack_err = 1'b0;
    txn_complete  = 1'b0;
  endtask

  task automatic start_cond();
    m_oe = 1'b0; q();
    bus.scl = 1'b1; q();
    m_oe = 1'b1;
    model_busy = 1'b1; model_ack_err = 1'b0; txn_complete = 1'b0; mark();
    q();
    bus.scl = 1'b0; q();
  endtask

  task automatic stop_cond();
    m_oe = 1'b1; q();
    bus.scl = 1'b1; q();
    m_oe = 1'b0;
    if (txn_complete) exp_done++;
    model_busy = 1'b0; txn_complete = 1'b0; mark();
    q();
    check("sda_released_after_stop", sda, 1'b1);
  endtask

  task automatic send_bit(input logic b);
    m_oe = ~b; q();
    bus.scl = 1'b1; q(); q();
    bus.scl = 1'b0; q();
  endtask

  task automatic recv_bit(output logic b);
    m_oe = 1'b0; q();
    bus.scl = 1'b1; q();
    b = sda; q();
    bus.scl = 1'b0; q();
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic recv_byte(output logic [7:0] v);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      v[i] = b;
    end
  endtask

  task automatic master_ack(input logic nack);
    m_oe = ~nack; q();
    bus.scl = 1'b1;
    if (nack) begin model_ack_err = 1'b1; mark(); end
    q(); q();
    bus.scl = 1'b0; q();
  endtask

  task automatic send_addr(input logic [6:0] a, input logic rw);
    logic ack;
    send_byte({a, rw});
    recv_bit(ack);
    check("addr_ack", ack, 1'b0);
  endtask

  task automatic write_txn(input logic [6:0] a, input logic [7:0] d);
    logic ack;
    start_cond();
    send_addr(a, 1'b0);
    exp_wr++;
    model_mem[a] = d;
    send_byte(d);
    recv_bit(ack);
    check("data_ack", ack, 1'b0);
    txn_complete = 1'b1;
    stop_cond();
  endtask

  task automatic read_txn(input logic [6:0] a, input logic nack, output logic [7:0] d);
    start_cond();
    send_addr(a, 1'b1);
    recv_byte(d);
    check("rd_data_vs_model", d, model_mem[a]);
    master_ack(nack);
    txn_complete = 1'b1;
    stop_cond();
  endtask

  initial begin
    rst = 1'b0; m_oe = 1'b0; bus.scl = 1'b1;
    checks = 0; failures = 0; exp_wr = 0; exp_done = 0; act_wr = 0; act_done = 0;
    cycle_cnt = 0; last_evt = 0; sim_done = 1'b0;
    model_reset();
    fork
      begin : stimulus
        repeat (4) @(negedge clk);
        check("reset_busy", bus.busy, 1'b0);
        check("reset_done", bus.done, 1'b0);
        check("reset_ack_err", bus.ack_err, 1'b0);
        check("reset_wr_strobe", bus.wr_strobe, 1'b0);
        check("reset_sda", sda, 1'b1);
        rst = 1'b1; mark();
        q();

        // Unwritten location reads as zero
        read_txn(7'h7F, 1'b1, rd);
        check("rd_7f_literal", rd, 8'h00);
        check("ack_err_after_nack", bus.ack_err, 1'b1);

        write_txn(7'h11, 8'h5A);
        check("model_mem_11_literal", model_mem[7'h11], 8'h5A);
        check("wr_count_s1", act_wr, 1);
        check("done_count_s1", act_done, 2);
        check("ack_err_after_write", bus.ack_err, 1'b0);

        read_txn(7'h11, 1'b1, rd);
        check("rd_11_literal", rd, 8'h5A);
        check("ack_err_s2", bus.ack_err, 1'b1);
        check("done_count_s2", act_done, exp_done);

        read_txn(7'h11, 1'b0, rd);
        check("rd_11_acked", rd, 8'h5A);
        check("ack_err_master_ack", bus.ack_err, 1'b0);

        // Reset in the 4th data bit of a write
        start_cond();
        send_addr(7'h22, 1'b0);
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
        m_oe = 1'b0; q();
        bus.scl = 1'b1; q();
        rst = 1'b0;
        model_reset(); mark();
        #1;
        check("mid_reset_sda", sda, 1'b1);
        check("mid_reset_busy", bus.busy, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1; mark();
        q();
        check("mid_reset_no_wr", act_wr, exp_wr);
        read_txn(7'h22, 1'b1, rd);
        check("rd_22_after_reset", rd, 8'h00);
        read_txn(7'h11, 1'b1, rd);
        check("rd_11_cleared", rd, 8'h00);

        // Aborted write, then repeated START into a good write
        start_cond();
        send_addr(7'h33, 1'b0);
        stop_cond();
        check("abort_no_done", act_done, exp_done);
        start_cond();
        send_addr(7'h40, 1'b0);
        begin
          logic ack;
          start_cond();
          send_addr(7'h01, 1'b0);
          exp_wr++;
          model_mem[7'h01] = 8'hA5;
          send_byte(8'hA5);
          recv_bit(ack);
          check("rs_data_ack", ack, 1'b0);
          txn_complete = 1'b1;
          stop_cond();
        end
        read_txn(7'h01, 1'b1, rd);
        check("rd_01_literal", rd, 8'hA5);
        read_txn(7'h40, 1'b1, rd);
        check("rd_40_unchanged", rd, 8'h00);
        read_txn(7'h33, 1'b1, rd);
        check("rd_33_unchanged", rd, 8'h00);

        // SDA glitch with SCL low while idle
        bus.scl = 1'b0; q();
        m_oe = 1'b1; repeat (3) @(negedge clk);
        m_oe = 1'b0; q();
        bus.scl = 1'b1; q();
        check("glitch_busy", bus.busy, 1'b0);

        check("final_wr_count", act_wr, exp_wr);
        check("final_done_count", act_done, exp_done);
        sim_done = 1'b1;
      end
      begin : compare
        while (!sim_done) begin
          @(negedge clk);
          cycle_cnt++;
          if (bus.wr_strobe) begin
            act_wr++;
            check("wr_strobe_allowed", (act_wr <= exp_wr), 1'b1);
          end
          if (bus.done) begin
            act_done++;
            check("done_allowed", (act_done <= exp_done), 1'b1);
          end
          if (rst && (cycle_cnt - last_evt) > 6) begin
            check("busy_vs_model", bus.busy, model_busy);
            check("ack_err_vs_model", bus.ack_err, model_ack_err);
          end
          if (cycle_cnt > 90000) begin
            check("cycle_budget", 1'b1, 1'b0);
            sim_done = 1'b1;
          end
        end
      end
    join
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
